jm_cmpl_arbiter: RTL and testbench
==================================

JM_CMPL_ARBITER -- requirements
Module: jm_cmpl_arbiter

Interface
REQ-001 SHALL have parameter KERNEL_NUM, default 2, number of kernel completion requesters (1..16).
REQ-002 SHALL have parameter RETURN_WIDTH, default 41, width of one kernel return word.
REQ-003 SHALL have parameter KID_WIDTH, default 4, width of the granted kernel index (at least clog2(KERNEL_NUM)).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 complete_ready  in  KERNEL_NUM  bit k high: kernel k holds a completion; held until its accept.
REQ-007 complete_data  in  RETURN_WIDTH*KERNEL_NUM  slice k is kernel k return word; stable while complete_ready[k] is high.
REQ-008 complete_accept  out  KERNEL_NUM  one-hot, one-cycle pulse taking kernel k's completion.
REQ-009 complete_ready_i  in  1  downstream completion writer can take a push.
REQ-010 complete_push_o  out  1  one-cycle push of return_data_o.
REQ-011 return_data_o  out  RETURN_WIDTH  captured return word; valid while complete_push_o is high.
REQ-012 cmpl_kid_o  out  KID_WIDTH  index of the kernel whose word is being pushed.
REQ-013 cmpl_count_o  out  32  total pushes since reset.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD and PUSH.
REQ-015 IDLE: if any complete_ready bit is high, latch grant g and go to LOAD next cycle; otherwise stay in IDLE.
REQ-016 Grant SHALL be round-robin: first requester searching upward from last_grant+1, wrapping KERNEL_NUM-1 to 0.
REQ-017 After reset last_grant SHALL be KERNEL_NUM-1, so kernel 0 has first priority.
REQ-018 LOAD: complete_accept[g]=1 for exactly that cycle; complete_data slice g is captured into return_data_o; cmpl_kid_o=g; last_grant updates to g; next state is PUSH.
REQ-019 PUSH: complete_push_o=1 only in a cycle where complete_ready_i=1; that cycle cmpl_count_o increments and next state is IDLE; while complete_ready_i=0, stay in PUSH with the data held.
REQ-020 Minimum latency from complete_ready rising in IDLE to complete_push_o SHALL be 2 cycles; throughput is at most one completion per 3 cycles.
REQ-021 Requests arriving in LOAD or PUSH SHALL only be arbitrated on the next IDLE cycle.
REQ-022 complete_accept SHALL never have more than one bit set, and SHALL never be set outside LOAD.
REQ-023 A granted kernel dropping complete_ready in LOAD SHALL still be accepted and its data pushed; this is a kernel protocol violation, but the arbiter does not check it.
REQ-024 cmpl_count_o SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 return_data_o and cmpl_kid_o SHALL hold their last values outside PUSH.

Reset
REQ-026 With resetn=0 at a clock edge: FSM goes to IDLE; complete_accept=0, complete_push_o=0, return_data_o=0, cmpl_kid_o=0, cmpl_count_o=0, last_grant=KERNEL_NUM-1.
REQ-027 Reset in LOAD or PUSH SHALL discard the captured completion without a push; no accept pulse SHALL be issued in the reset cycle.

Structure
REQ-028 Shared package jm_pkg SHALL hold the FSM state enum and the cmpl_count width constant.
REQ-029 Round-robin selection SHALL be a sub-module jm_rr_arbiter (inputs req, last_grant; output grant index plus a valid flag), purely combinational; last_grant is registered in jm_cmpl_arbiter.

Verification
REQ-030 Single request: KERNEL_NUM=2, complete_ready=01, complete_ready_i=1 -> complete_accept=01 at cycle 1, push at cycle 2 with slice 0 data, cmpl_kid_o=0, cmpl_count_o=1.
REQ-031 Round-robin fairness: KERNEL_NUM=4, all ready held high, each kernel drops ready after its accept then re-raises it -> grant order 0,1,2,3,0,1; no kernel granted twice before the others.
REQ-032 Backpressure: complete_ready_i=0 for 10 cycles in PUSH -> no push, return_data_o stable, no further accept; push occurs on the first cycle complete_ready_i=1.
REQ-033 Wrap: cmpl_count_o preloaded/forced to 0xFFFFFFFF, one push -> cmpl_count_o=0.
REQ-034 Reset mid-operation: resetn=0 during PUSH -> no push, all outputs 0, next grant goes to kernel 0.

Source files
------------

// File: rtl/jm_pkg.sv
// Shared definitions for the kernel completion arbiter slice:
// the arbiter FSM state encoding and the completion counter width.
package jm_pkg;

    localparam int CMPL_COUNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PUSH = 2'd2
    } jm_state_e;

endpackage

// File: rtl/jm_rr_arbiter.sv
// Combinational round-robin picker. It starts searching just above
// lastGrant and wraps from KERNEL_NUM-1 back to 0. The search runs as two
// halves. The "high" half covers indices above lastGrant. The "low" half
// covers indices at or below lastGrant. Any hit in the high half wins.
module jm_rr_arbiter #(
    parameter int KERNEL_NUM = 2,
    parameter int KID_WIDTH  = 4
) (
    input  logic [KERNEL_NUM-1:0] req_i,
    input  logic [KID_WIDTH-1:0]  last_grant_i,
    output logic [KID_WIDTH-1:0]  grant_o,
    output logic                  valid_o
);

    logic                 hiFound;
    logic                 loFound;
    logic [KID_WIDTH-1:0] hiIdx;
    logic [KID_WIDTH-1:0] loIdx;

    // Scan downward so that the lowest requester in each half is the one left standing
    always_comb begin
        hiFound = 1'b0;
        loFound = 1'b0;
        hiIdx   = '0;
        loIdx   = '0;
        for (int j = KERNEL_NUM - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                if (j > int'(last_grant_i)) begin
                    hiFound = 1'b1;
                    hiIdx   = KID_WIDTH'(j);
                end else begin
                    loFound = 1'b1;
                    loIdx   = KID_WIDTH'(j);
                end
            end
        end
        grant_o = hiFound ? hiIdx : loIdx;
        valid_o = hiFound | loFound;
    end

endmodule

// File: rtl/jm_cmpl_arbiter.sv
// Kernel completion arbiter. It picks one pending kernel completion
// round-robin and accepts it with a one-cycle pulse. It then captures that
// kernel's return word and pushes the word to the downstream writer when the
// writer is ready. Each completion takes IDLE -> LOAD -> PUSH.
module jm_cmpl_arbiter
    import jm_pkg::*;
#(
    parameter int KERNEL_NUM   = 2,
    parameter int RETURN_WIDTH = 41,
    parameter int KID_WIDTH    = 4
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [KERNEL_NUM-1:0]            complete_ready,
    input  logic [RETURN_WIDTH*KERNEL_NUM-1:0] complete_data,
    output logic [KERNEL_NUM-1:0]            complete_accept,
    input  logic                             complete_ready_i,
    output logic                             complete_push_o,
    output logic [RETURN_WIDTH-1:0]          return_data_o,
    output logic [KID_WIDTH-1:0]             cmpl_kid_o,
    output logic [CMPL_COUNT_W-1:0]          cmpl_count_o
);

    jm_state_e                 state_q,      state_d;
    logic [KID_WIDTH-1:0]      grant_q,      grant_d;
    logic [KID_WIDTH-1:0]      lastGrant_q,  lastGrant_d;
    logic [RETURN_WIDTH-1:0]   returnData_q, returnData_d;
    logic [KID_WIDTH-1:0]      kid_q,        kid_d;
    logic [CMPL_COUNT_W-1:0]   cmplCount_q,  cmplCount_d;

    logic [KID_WIDTH-1:0]      arbGrant;
    logic                      arbValid;

    jm_rr_arbiter #(
        .KERNEL_NUM (KERNEL_NUM),
        .KID_WIDTH  (KID_WIDTH)
    ) u_rr (
        .req_i        (complete_ready),
        .last_grant_i (lastGrant_q),
        .grant_o      (arbGrant),
        .valid_o      (arbValid)
    );

    // Next-state logic: IDLE latches the grant. LOAD captures the word and moves the priority pointer. PUSH waits for the writer.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        lastGrant_d  = lastGrant_q;
        returnData_d = returnData_q;
        kid_d        = kid_q;
        cmplCount_d  = cmplCount_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arbValid) begin
                    grant_d = arbGrant;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                for (int j = 0; j < KERNEL_NUM; j++) begin
                    if (grant_q == KID_WIDTH'(j)) begin
                        returnData_d = complete_data[j*RETURN_WIDTH +: RETURN_WIDTH];
                    end
                end
                kid_d       = grant_q;
                lastGrant_d = grant_q;
                state_d     = ST_PUSH;
            end
            ST_PUSH: begin
                if (complete_ready_i) begin
                    cmplCount_d = cmplCount_q + CMPL_COUNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes decode from the current state and are held off while reset is asserted, so a reset cycle never accepts or pushes
    always_comb begin
        complete_accept = '0;
        for (int j = 0; j < KERNEL_NUM; j++) begin
            complete_accept[j] = resetn && (state_q == ST_LOAD) && (grant_q == KID_WIDTH'(j));
        end
        complete_push_o = resetn && (state_q == ST_PUSH) && complete_ready_i;
    end

    // State registers with synchronous active-low reset; the priority pointer resets to the top so kernel 0 goes first
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            lastGrant_q  <= KID_WIDTH'(KERNEL_NUM - 1);
            returnData_q <= '0;
            kid_q        <= '0;
            cmplCount_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            lastGrant_q  <= lastGrant_d;
            returnData_q <= returnData_d;
            kid_q        <= kid_d;
            cmplCount_q  <= cmplCount_d;
        end
    end

    assign return_data_o = returnData_q;
    assign cmpl_kid_o    = kid_q;
    assign cmpl_count_o  = cmplCount_q;

endmodule

// File: tb/tb_jm_cmpl_arbiter.sv
// Self-checking bench for jm_cmpl_arbiter with four kernels.
// Expected completions (kernel index and return word) are queued as each
// scenario is set up. The monitor pops them as pushes appear.
module tb_jm_cmpl_arbiter;

    localparam int K  = 4;
    localparam int RW = 41;
    localparam int KW = 4;

    typedef struct {
        logic [KW-1:0] kid;
        logic [RW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            resetn;
    logic [K-1:0]    complete_ready;
    logic [RW*K-1:0] complete_data;
    logic [K-1:0]    complete_accept;
    logic            complete_ready_i;
    logic            complete_push_o;
    logic [RW-1:0]   return_data_o;
    logic [KW-1:0]   cmpl_kid_o;
    logic [31:0]     cmpl_count_o;

    int           vectors     = 0;
    int           miscompares = 0;
    exp_t         expQ[$];
    logic [31:0]  expCount;
    logic [K-1:0] dropPending;
    logic [K-1:0] rearmPending;
    bit           autoDrop;
    bit           autoRearm;

    jm_cmpl_arbiter #(
        .KERNEL_NUM   (K),
        .RETURN_WIDTH (RW),
        .KID_WIDTH    (KW)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .complete_ready   (complete_ready),
        .complete_data    (complete_data),
        .complete_accept  (complete_accept),
        .complete_ready_i (complete_ready_i),
        .complete_push_o  (complete_push_o),
        .return_data_o    (return_data_o),
        .cmpl_kid_o       (cmpl_kid_o),
        .cmpl_count_o     (cmpl_count_o)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Hard stop in case the sequence wedges somewhere unexpected
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Distinct return word per kernel and scenario tag
    function automatic logic [RW-1:0] mkWord(input int k, input int tag);
        return {9'(tag), 32'hC0DE_0000 + 32'(k * 32'h111)};
    endfunction

    task automatic setWord(input int k, input logic [RW-1:0] w);
        complete_data[k*RW +: RW] = w;
    endtask

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Negedge monitor. An accept must be one-hot and match the head of the queue. A push pops the queue and checks kid, data and the count before it increments.
    task automatic checkOutput();
        int   idx;
        exp_t e;
        if (complete_accept !== '0) begin
            idx = 0;
            for (int k = 0; k < K; k++) if (complete_accept[k]) idx = k;
            checkVal("accept_onehot", 64'($onehot(complete_accept)), 64'd1);
            if (expQ.size() == 0) checkVal("accept_unexpected", 64'(complete_accept), 64'd0);
            else                  checkVal("accept_kid", 64'(idx), 64'(expQ[0].kid));
            if (autoDrop) dropPending[idx] = 1'b1;
        end
        if (complete_push_o === 1'b1) begin
            checkVal("push_needs_ready", 64'(complete_ready_i), 64'd1);
            if (expQ.size() == 0) begin
                checkVal("push_unexpected", 64'(complete_push_o), 64'd0);
            end else begin
                e = expQ.pop_front();
                checkVal("push_kid", 64'(cmpl_kid_o), 64'(e.kid));
                checkVal("push_data", 64'(return_data_o), 64'(e.data));
                checkVal("push_count", 64'(cmpl_count_o), 64'(expCount));
                expCount = expCount + 32'd1;
            end
        end
    endtask

    // Kernel behaviour after the capture edge: drop ready once accepted, optionally re-raise it a cycle later
    task automatic applyStimulus();
        complete_ready = complete_ready | rearmPending;
        rearmPending   = '0;
        complete_ready = complete_ready & ~dropPending;
        if (autoRearm) rearmPending = dropPending;
        dropPending = '0;
    endtask

    // One clock: monitor at negedge, then kernel reactions just after the rising edge
    task automatic cycle();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        applyStimulus();
    endtask

    task automatic runUntilDrained(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        checkVal("drain_timeout", 64'(expQ.size()), 64'd0);
    endtask

    // Directed scenario sequence
    initial begin
        resetn           = 1'b0;
        complete_ready   = '0;
        complete_data    = '0;
        complete_ready_i = 1'b1;
        autoDrop         = 1'b0;
        autoRearm        = 1'b0;
        dropPending      = '0;
        rearmPending     = '0;
        expCount         = 32'd0;

        @(posedge clk);
        #1;
        cycle();
        checkVal("rst_accept", 64'(complete_accept), 64'd0);
        checkVal("rst_push",   64'(complete_push_o), 64'd0);
        checkVal("rst_data",   64'(return_data_o),   64'd0);
        checkVal("rst_kid",    64'(cmpl_kid_o),      64'd0);
        checkVal("rst_count",  64'(cmpl_count_o),    64'd0);
        resetn = 1'b1;

        // Single request: accept one cycle after ready, push the cycle after that
        $display("[TB] single request");
        autoDrop = 1'b1;
        setWord(0, mkWord(0, 0));
        complete_ready = 4'b0001;
        expQ.push_back('{kid: 4'd0, data: mkWord(0, 0)});
        cycle();
        checkVal("single_accept_c1", 64'(complete_accept), 64'b0001);
        checkVal("single_nopush_c1", 64'(complete_push_o), 64'd0);
        cycle();
        checkVal("single_push_c2",   64'(complete_push_o), 64'd1);
        checkVal("single_data_c2",   64'(return_data_o),   64'(mkWord(0, 0)));
        checkVal("single_kid_c2",    64'(cmpl_kid_o),      64'd0);
        cycle();
        checkVal("single_count",     64'(cmpl_count_o),    64'd1);
        checkVal("single_idle_push", 64'(complete_push_o), 64'd0);

        // Fresh reset so fairness starts from kernel 0
        resetn = 1'b0;
        cycle();
        resetn   = 1'b1;
        expCount = 32'd0;

        // Fairness: all kernels keep re-raising ready; grants must rotate 0,1,2,3,0,1
        $display("[TB] round-robin fairness");
        for (int k = 0; k < K; k++) setWord(k, mkWord(k, 1));
        autoRearm      = 1'b1;
        complete_ready = 4'b1111;
        for (int n = 0; n < 6; n++) expQ.push_back('{kid: KW'(n % K), data: mkWord(n % K, 1)});
        runUntilDrained(40);
        complete_ready = '0;
        autoRearm      = 1'b0;
        rearmPending   = '0;
        checkVal("fair_count", 64'(cmpl_count_o), 64'(expCount));

        // Backpressure: writer not ready for ten cycles while a word waits in PUSH
        $display("[TB] backpressure");
        complete_ready_i = 1'b0;
        setWord(2, mkWord(2, 2));
        complete_ready = 4'b0100;
        expQ.push_back('{kid: 4'd2, data: mkWord(2, 2)});
        cycle();
        cycle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            checkVal("bp_nopush",   64'(complete_push_o), 64'd0);
            checkVal("bp_data",     64'(return_data_o),   64'(mkWord(2, 2)));
            checkVal("bp_noaccept", 64'(complete_accept), 64'd0);
        end
        complete_ready_i = 1'b1;
        #1;
        checkVal("bp_release_push", 64'(complete_push_o), 64'd1);
        cycle();
        checkVal("bp_count", 64'(cmpl_count_o), 64'(expCount));

        // Counter wrap: preload all ones, one push must roll over to zero
        $display("[TB] count wrap");
        force dut.cmplCount_q = 32'hFFFF_FFFF;
        #1;
        release dut.cmplCount_q;
        expCount = 32'hFFFF_FFFF;
        #1;
        checkVal("wrap_preload", 64'(cmpl_count_o), 64'hFFFF_FFFF);
        setWord(3, mkWord(3, 3));
        complete_ready = 4'b1000;
        expQ.push_back('{kid: 4'd3, data: mkWord(3, 3)});
        runUntilDrained(10);
        checkVal("wrap_zero", 64'(cmpl_count_o), 64'd0);

        // Reset while holding a word in PUSH: no push, everything cleared, kernel 0 first again
        $display("[TB] reset mid-operation");
        complete_ready_i = 1'b0;
        setWord(1, mkWord(1, 4));
        complete_ready = 4'b0010;
        expQ.push_back('{kid: 4'd1, data: mkWord(1, 4)});
        cycle();
        cycle();
        resetn           = 1'b0;
        complete_ready_i = 1'b1;
        #1;
        checkVal("midrst_no_push", 64'(complete_push_o), 64'd0);
        cycle();
        checkVal("midrst_accept", 64'(complete_accept), 64'd0);
        checkVal("midrst_push",   64'(complete_push_o), 64'd0);
        checkVal("midrst_data",   64'(return_data_o),   64'd0);
        checkVal("midrst_kid",    64'(cmpl_kid_o),      64'd0);
        checkVal("midrst_count",  64'(cmpl_count_o),    64'd0);
        expQ.delete();
        expCount = 32'd0;
        resetn   = 1'b1;
        setWord(0, mkWord(0, 5));
        setWord(2, mkWord(2, 5));
        complete_ready = 4'b0101;
        expQ.push_back('{kid: 4'd0, data: mkWord(0, 5)});
        expQ.push_back('{kid: 4'd2, data: mkWord(2, 5)});
        runUntilDrained(20);
        checkVal("midrst_final_count", 64'(cmpl_count_o), 64'(expCount));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
